video_tg_axil_slave: RTL and testbench

VIDEO_TG_AXIL_SLAVE -- requirements
Module: video_tg_axil_slave

---
 rtl/video_tg_axil_slave.sv | 163 ++++++++++++++++
 tb/tb_video_tg_axil_slave.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_tg_axil_slave.sv
// Video timing generator with an AXI4-Lite register slave.
//
// Registers (byte address, bits [1:0] ignored):
//   0x0 CTRL     [0] enable
//   0x4 H_TOTAL  [11:0] pixels per line
//   0x8 V_TOTAL  [11:0] lines per frame
//   0xC SYNC     [11:0] hsync width, [27:16] vsync width
// All four registers keep the full 32 bits written.
//
// Ports:
//   ACLK, ARESET          clock, asynchronous active-high reset
//   AW*/W*/B*             AXI4-Lite write channels (AWPROT ignored)
//   AR*/R*                AXI4-Lite read channels (ARPROT ignored)
//   hcount, vcount        pixel / line counters
//   hsync, vsync          sync pulses, registered with the counters
//   frame_start           one-cycle pulse at counter position (0,0)
module video_tg_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]                      AWPROT,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]                      ARPROT,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RVALID,
  input  logic                            RREADY,
  output logic [11:0]                     hcount,
  output logic [11:0]                     vcount,
  output logic                            hsync,
  output logic                            vsync,
  output logic                            frame_start
);

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
  logic wr_en, rd_en;
  logic unused_bits;

  assign unused_bits = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

  // Ready is combinational so a request can be taken on the very first edge
  // it is presented, including the first edge after reset.
  assign AWREADY = !ARESET && AWVALID && WVALID && !BVALID;
  assign WREADY  = AWREADY;
  assign ARREADY = !ARESET && ARVALID && !RVALID;
  assign wr_en   = AWREADY;
  assign rd_en   = ARREADY;
  assign BRESP   = 2'b00;
  assign RRESP   = 2'b00;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int r = 0; r < 4; r++) regs[r] <= '0;
      BVALID <= 1'b0;
    end else begin
      if (wr_en) begin
        for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++)
          if (WSTRB[b]) regs[AWADDR[3:2]][8*b +: 8] <= WDATA[8*b +: 8];
        BVALID <= 1'b1;
      end else if (BREADY) begin
        BVALID <= 1'b0;
      end
    end
  end

  // Read data samples the register array before any same-edge write lands.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
    end else begin
      if (rd_en) begin
        RVALID <= 1'b1;
        RDATA  <= regs[ARADDR[3:2]];
      end else if (RREADY) begin
        RVALID <= 1'b0;
      end
    end
  end

  // Timing generator
  logic        en, en_q, cfg_zero, frame_end, load;
  logic [11:0] act_h, act_v, act_hs, act_vs;
  logic [11:0] use_h, use_v, use_hs, use_vs;
  logic [11:0] h_nxt, v_nxt;
  logic        hsync_nxt, vsync_nxt, fs_nxt;

  always_comb begin
    en        = regs[0][0];
    cfg_zero  = (act_h == 12'd0) || (act_v == 12'd0);
    frame_end = (hcount == act_h - 12'd1) && (vcount == act_v - 12'd1);
    // A zero-sized active config has no frame to finish, so it keeps
    // re-sampling the registers until a usable geometry appears.
    load      = !en_q || cfg_zero || frame_end;
    use_h     = load ? regs[1][11:0]  : act_h;
    use_v     = load ? regs[2][11:0]  : act_v;
    use_hs    = load ? regs[3][11:0]  : act_hs;
    use_vs    = load ? regs[3][27:16] : act_vs;
    h_nxt     = 12'd0;
    v_nxt     = 12'd0;
    if (!load) begin
      if (hcount == act_h - 12'd1) begin
        v_nxt = vcount + 12'd1;
      end else begin
        h_nxt = hcount + 12'd1;
        v_nxt = vcount;
      end
    end
    fs_nxt    = (use_h != 12'd0) && (use_v != 12'd0) && (h_nxt == 12'd0) && (v_nxt == 12'd0);
    hsync_nxt = h_nxt < use_hs;
    vsync_nxt = v_nxt < use_vs;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      en_q        <= 1'b0;
      act_h       <= '0;
      act_v       <= '0;
      act_hs      <= '0;
      act_vs      <= '0;
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
    end else if (!en) begin
      en_q        <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      en_q <= 1'b1;
      if (load) begin
        act_h  <= use_h;
        act_v  <= use_v;
        act_hs <= use_hs;
        act_vs <= use_vs;
      end
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      frame_start <= fs_nxt;
    end
  end

endmodule

// File: tb/tb_video_tg_axil_slave.sv
// Directed bench for video_tg_axil_slave: register access, strobes,
// backpressure, same-cycle read/write, timing generation and reset.
module tb_video_tg_axil_slave;

  logic        ACLK, ARESET;
  logic [3:0]  AWADDR, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [11:0] hcount, vcount;
  logic        hsync, vsync, frame_start;

  int n_vec = 0;
  int n_err = 0;

  video_tg_axil_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Returns the number of clock edges consumed (2 when accepted immediately).
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output int ncyc);
    logic hs;
    int t;
    ncyc = 0;
    AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1'b1; WVALID = 1'b1;
    hs = 1'b0; t = 0;
    while (!hs && t < 20) begin
      @(negedge ACLK); hs = AWREADY && WREADY;
      @(posedge ACLK); #1; ncyc++; t++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    check("aw_accept", {31'd0, hs}, 32'd1);
    BREADY = 1'b1; hs = 1'b0; t = 0;
    while (!hs && t < 20) begin
      @(negedge ACLK); hs = BVALID;
      if (hs) check("bresp", {30'd0, BRESP}, 32'd0);
      @(posedge ACLK); #1; ncyc++; t++;
    end
    BREADY = 1'b0;
    check("b_seen", {31'd0, hs}, 32'd1);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    logic hs;
    int t;
    data = 32'hDEAD_BEEF;
    ARADDR = addr; ARVALID = 1'b1;
    hs = 1'b0; t = 0;
    while (!hs && t < 20) begin
      @(negedge ACLK); hs = ARREADY;
      @(posedge ACLK); #1; t++;
    end
    ARVALID = 1'b0;
    check("ar_accept", {31'd0, hs}, 32'd1);
    RREADY = 1'b1; hs = 1'b0; t = 0;
    while (!hs && t < 20) begin
      @(negedge ACLK); hs = RVALID;
      if (hs) begin
        data = RDATA;
        check("rresp", {30'd0, RRESP}, 32'd0);
      end
      @(posedge ACLK); #1; t++;
    end
    RREADY = 1'b0;
    check("r_seen", {31'd0, hs}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int nc, i, p, hw, eh, ev;

    ARESET = 1'b1;
    AWADDR = '0; AWPROT = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0; ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
    #1;
    check("rst_bvalid", {31'd0, BVALID}, 32'd0);
    check("rst_rvalid", {31'd0, RVALID}, 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    check("rst_hcount", {20'd0, hcount}, 32'd0);
    check("rst_fs", {31'd0, frame_start}, 32'd0);
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;

    // Register write/readback; first write must be accepted on the first edge
    axi_write(4'h0, 32'h1, 4'hF, nc);
    check("first_accept_cycles", nc, 2);
    axi_write(4'h4, 32'h2, 4'hF, nc);
    axi_write(4'h8, 32'h3, 4'hF, nc);
    axi_write(4'hC, 32'h4, 4'hF, nc);
    axi_read(4'h0, rd); check("rd_ctrl", rd, 32'h1);
    axi_read(4'h4, rd); check("rd_htot", rd, 32'h2);
    axi_read(4'h8, rd); check("rd_vtot", rd, 32'h3);
    axi_read(4'hF, rd); check("rd_sync_lowbits_ignored", rd, 32'h4);

    // Byte strobes
    axi_write(4'h4, 32'hAABBCCDD, 4'hF, nc);
    axi_write(4'h4, 32'h00001100, 4'b0010, nc);
    axi_read(4'h4, rd); check("strb_byte1", rd, 32'hAABB11DD);
    axi_write(4'h4, 32'h99000000, 4'b1000, nc);
    axi_read(4'h4, rd); check("strb_byte3", rd, 32'h99BB11DD);

    // Partial presentation must not be accepted
    AWADDR = 4'h8; AWVALID = 1'b1;
    repeat (3) begin
      @(negedge ACLK); check("aw_only_ready", {31'd0, AWREADY}, 32'd0);
      @(posedge ACLK); #1;
    end
    AWVALID = 1'b0; WDATA = 32'h1234; WSTRB = 4'hF; WVALID = 1'b1;
    repeat (3) begin
      @(negedge ACLK); check("w_only_ready", {31'd0, WREADY}, 32'd0);
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0;
    check("partial_no_b", {31'd0, BVALID}, 32'd0);

    // Backpressure on B with a second write waiting
    AWADDR = 4'h8; WDATA = 32'h55; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    @(negedge ACLK); check("bp_first_ready", {31'd0, AWREADY}, 32'd1);
    @(posedge ACLK); #1;
    AWADDR = 4'hC; WDATA = 32'h66;
    repeat (10) begin
      @(negedge ACLK);
      check("bp_bvalid_held", {31'd0, BVALID}, 32'd1);
      check("bp_no_accept", {30'd0, AWREADY, WREADY}, 32'd0);
      @(posedge ACLK); #1;
    end
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    @(negedge ACLK); check("bp_second_ready", {31'd0, AWREADY}, 32'd1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    @(negedge ACLK); check("bp_second_b", {31'd0, BVALID}, 32'd1);
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    axi_read(4'h8, rd); check("bp_rd_first", rd, 32'h55);
    axi_read(4'hC, rd); check("bp_rd_second", rd, 32'h66);

    // Read and write to the same register in the same cycle
    AWADDR = 4'hC; WDATA = 32'h77; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    ARADDR = 4'hC; ARVALID = 1'b1;
    @(negedge ACLK);
    check("rw_both_ready", {30'd0, AWREADY, ARREADY}, 32'd3);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0; BREADY = 1'b1; RREADY = 1'b1;
    @(negedge ACLK);
    check("rw_valids", {30'd0, BVALID, RVALID}, 32'd3);
    check("rw_old_value", RDATA, 32'h66);
    @(posedge ACLK); #1;
    BREADY = 1'b0; RREADY = 1'b0;
    axi_read(4'hC, rd); check("rw_new_value", rd, 32'h77);

    // Disable clears the generator
    axi_write(4'h0, 32'h0, 4'hF, nc);
    check("dis_hcount", {20'd0, hcount}, 32'd0);
    check("dis_outs", {29'd0, hsync, vsync, frame_start}, 32'd0);

    // 4x3 timing, then H_TOTAL=8 written mid-frame (active from frame at i=36)
    axi_write(4'h4, 32'd4, 4'hF, nc);
    axi_write(4'h8, 32'd3, 4'hF, nc);
    axi_write(4'hC, 32'h00010001, 4'hF, nc);
    axi_write(4'h0, 32'h1, 4'hF, nc);
    i = 0;
    while (i < 72) begin
      if (i < 36) begin p = i % 12; hw = 4; end
      else begin p = (i - 36) % 24; hw = 8; end
      eh = p % hw; ev = p / hw;
      check("tg_hcount", {20'd0, hcount}, eh);
      check("tg_vcount", {20'd0, vcount}, ev);
      check("tg_hsync", {31'd0, hsync}, (eh == 0) ? 32'd1 : 32'd0);
      check("tg_vsync", {31'd0, vsync}, (ev == 0) ? 32'd1 : 32'd0);
      check("tg_fs", {31'd0, frame_start}, (p == 0) ? 32'd1 : 32'd0);
      if (i == 23) begin
        axi_write(4'h4, 32'd8, 4'hF, nc);
        i += nc;
      end else begin
        @(posedge ACLK); #1; i++;
      end
    end

    // Reset while a read response is pending
    ARADDR = 4'h0; ARVALID = 1'b1;
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    @(negedge ACLK);
    check("pre_rst_rvalid", {31'd0, RVALID}, 32'd1);
    check("pre_rst_running", {31'd0, (hcount != 12'd0) || (vcount != 12'd0)}, 32'd1);
    ARESET = 1'b1;
    #1;
    check("arst_rvalid", {31'd0, RVALID}, 32'd0);
    check("arst_rdata", RDATA, 32'd0);
    check("arst_counters", {8'd0, hcount, vcount}, 32'd0);
    check("arst_outs", {29'd0, hsync, vsync, frame_start}, 32'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    repeat (3) begin
      @(negedge ACLK); check("post_rst_no_resp", {30'd0, BVALID, RVALID}, 32'd0);
    end
    @(posedge ACLK); #1;
    axi_read(4'h0, rd); check("post_rst_ctrl", rd, 32'h0);
    axi_read(4'h4, rd); check("post_rst_htot", rd, 32'h0);

    // Enabled with zero totals: counters hold, no frame_start
    axi_write(4'h0, 32'h1, 4'hF, nc);
    repeat (5) begin
      check("zero_cfg_counters", {8'd0, hcount, vcount}, 32'd0);
      check("zero_cfg_fs", {31'd0, frame_start}, 32'd0);
      @(posedge ACLK); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
